// File: rtl/rf_pkg.sv
// Shared constants and types for the register-file writeback scheduler.
package rf_pkg;

    localparam int RF_ADDR_WIDTH = 5;
    localparam int RF_DATA_WIDTH = 32;

    typedef struct packed {
        logic [RF_ADDR_WIDTH-1:0] addr;
        logic [RF_DATA_WIDTH-1:0] data;
    } wb_req_t;

    // Width needed to hold an occupancy count in 0..depth.
    function automatic int count_width(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/rf_wb_fifo.sv
// Circular buffer of {addr, data} entries: up to two pushes and one pop per cycle.
// The pop is implicit: the head drains on every edge where the buffer is not empty.
module rf_wb_fifo
    import rf_pkg::*;
#(
    parameter int ADDR_WIDTH = RF_ADDR_WIDTH,
    parameter int DATA_WIDTH = RF_DATA_WIDTH,
    parameter int DEPTH      = 4,
    localparam int PW        = $clog2(DEPTH),
    localparam int CW        = count_width(DEPTH)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [1:0]            push_n,
    input  logic [ADDR_WIDTH-1:0] push0_addr,
    input  logic [DATA_WIDTH-1:0] push0_data,
    input  logic [ADDR_WIDTH-1:0] push1_addr,
    input  logic [DATA_WIDTH-1:0] push1_data,
    output logic [CW-1:0]         count,
    output logic [ADDR_WIDTH-1:0] head_addr,
    output logic [DATA_WIDTH-1:0] head_data,
    output logic [DEPTH-1:0]      occupied,
    output logic [ADDR_WIDTH-1:0] entry_addr [DEPTH]
);

    logic [ADDR_WIDTH-1:0] addr_mem [DEPTH];
    logic [DATA_WIDTH-1:0] data_mem [DEPTH];
    logic [PW-1:0]         rd_ptr;
    logic [PW-1:0]         wr_ptr;
    logic                  pop;

    assign pop = (count != '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
            // NOTE: storage is cleared on reset because the head slot drives rf_addr/rf_wd, which must read 0 out of reset.
            for (int i = 0; i < DEPTH; i++) begin
                addr_mem[i] <= '0;
                data_mem[i] <= '0;
            end
        end else begin
            // NOTE: non-blocking throughout so every register sees pre-edge values, independent of statement order.
            if (push_n != 2'd0) begin
                addr_mem[wr_ptr] <= push0_addr;
                data_mem[wr_ptr] <= push0_data;
            end
            if (push_n == 2'd2) begin
                addr_mem[wr_ptr + PW'(1)] <= push1_addr;
                data_mem[wr_ptr + PW'(1)] <= push1_data;
            end
            wr_ptr <= wr_ptr + PW'(push_n);
            if (pop) rd_ptr <= rd_ptr + PW'(1);
            count <= count + CW'(push_n) - CW'(pop);
        end
    end

    assign head_addr  = addr_mem[rd_ptr];
    assign head_data  = data_mem[rd_ptr];
    assign entry_addr = addr_mem;

    // Slot i is live when its distance from the head (mod DEPTH) is below count.
    always_comb begin
        // NOTE: default assignment first so no path through this block can infer a latch.
        occupied = '0;
        for (int i = 0; i < DEPTH; i++) begin
            occupied[i] = CW'(PW'(PW'(i) - rd_ptr)) < count;
        end
    end

endmodule

// File: rtl/rf_wb_scheduler.sv
// Merges two writeback lanes (A older, B younger) onto one register-file write port,
// dropping x0 writes and same-register A writes shadowed by B, with pending-write busy checks.
module rf_wb_scheduler
    import rf_pkg::*;
#(
    parameter int ADDR_WIDTH = RF_ADDR_WIDTH,
    parameter int DATA_WIDTH = RF_DATA_WIDTH,
    parameter int DEPTH      = 4
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          a_valid,
    input  logic [ADDR_WIDTH-1:0]         a_addr,
    input  logic [DATA_WIDTH-1:0]         a_data,
    output logic                          a_ready,
    input  logic                          b_valid,
    input  logic [ADDR_WIDTH-1:0]         b_addr,
    input  logic [DATA_WIDTH-1:0]         b_data,
    output logic                          b_ready,
    output logic                          rf_we,
    output logic [ADDR_WIDTH-1:0]         rf_addr,
    output logic [DATA_WIDTH-1:0]         rf_wd,
    input  logic [ADDR_WIDTH-1:0]         chk_addr1,
    input  logic [ADDR_WIDTH-1:0]         chk_addr2,
    output logic                          chk_busy1,
    output logic                          chk_busy2,
    output logic [count_width(DEPTH)-1:0] q_count,
    output logic                          q_empty
);

    localparam int CW = count_width(DEPTH);

    logic                  ready;
    logic                  a_acc;
    logic                  b_acc;
    logic                  a_keep;
    logic                  b_keep;
    logic [1:0]            push_n;
    logic [ADDR_WIDTH-1:0] push0_addr;
    logic [DATA_WIDTH-1:0] push0_data;
    logic [CW-1:0]         count;
    logic [DEPTH-1:0]      occupied;
    logic [ADDR_WIDTH-1:0] entry_addr [DEPTH];

    // Room for a full pair is kept at all times, so ready depends on state only.
    assign ready   = (count <= CW'(DEPTH - 2));
    assign a_ready = ready;
    assign b_ready = ready;

    assign a_acc  = a_valid && ready;
    assign b_acc  = b_valid && ready;
    assign b_keep = b_acc && (b_addr != '0);
    assign a_keep = a_acc && (a_addr != '0) && !(b_acc && (b_addr == a_addr));

    // Kept requests are packed so the older one always lands at wr_ptr.
    assign push_n     = {1'b0, a_keep} + {1'b0, b_keep};
    assign push0_addr = a_keep ? a_addr : b_addr;
    assign push0_data = a_keep ? a_data : b_data;

    rf_wb_fifo #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DEPTH)
    ) u_fifo (
        .clk        (clk),
        .rst_n      (rst_n),
        .push_n     (push_n),
        .push0_addr (push0_addr),
        .push0_data (push0_data),
        .push1_addr (b_addr),
        .push1_data (b_data),
        .count      (count),
        .head_addr  (rf_addr),
        .head_data  (rf_wd),
        .occupied   (occupied),
        .entry_addr (entry_addr)
    );

    assign rf_we   = (count != '0);
    assign q_count = count;
    assign q_empty = (count == '0);

    always_comb begin
        chk_busy1 = 1'b0;
        chk_busy2 = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (occupied[i] && (entry_addr[i] == chk_addr1)) chk_busy1 = 1'b1;
            if (occupied[i] && (entry_addr[i] == chk_addr2)) chk_busy2 = 1'b1;
        end
        if (chk_addr1 == '0) chk_busy1 = 1'b0;
        if (chk_addr2 == '0) chk_busy2 = 1'b0;
    end

endmodule

// File: tb/tb_rf_wb_scheduler.sv
// Bench for rf_wb_scheduler: queue-based reference model compared every cycle,
// directed scenarios with literal expectations, random traffic and an async reset pulse.
module tb_rf_wb_scheduler;
    import rf_pkg::*;

    localparam int DEPTH = 4;
    localparam int AW    = RF_ADDR_WIDTH;
    localparam int DW    = RF_DATA_WIDTH;
    localparam int CW    = count_width(DEPTH);

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          a_valid = 1'b0, b_valid = 1'b0;
    logic [AW-1:0] a_addr = '0, b_addr = '0;
    logic [DW-1:0] a_data = '0, b_data = '0;
    logic          a_ready, b_ready;
    logic          rf_we;
    logic [AW-1:0] rf_addr;
    logic [DW-1:0] rf_wd;
    logic [AW-1:0] chk_addr1 = '0, chk_addr2 = '0;
    logic          chk_busy1, chk_busy2;
    logic [CW-1:0] q_count;
    logic          q_empty;

    rf_wb_scheduler #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n),
        .a_valid(a_valid), .a_addr(a_addr), .a_data(a_data), .a_ready(a_ready),
        .b_valid(b_valid), .b_addr(b_addr), .b_data(b_data), .b_ready(b_ready),
        .rf_we(rf_we), .rf_addr(rf_addr), .rf_wd(rf_wd),
        .chk_addr1(chk_addr1), .chk_addr2(chk_addr2),
        .chk_busy1(chk_busy1), .chk_busy2(chk_busy2),
        .q_count(q_count), .q_empty(q_empty)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    endtask

    // Reference model: the pending writes in program order, head first.
    wb_req_t m_q[$];

    function automatic bit model_busy(input logic [AW-1:0] a);
        if (a == '0) return 1'b0;
        foreach (m_q[i]) if (m_q[i].addr == a) return 1'b1;
        return 1'b0;
    endfunction

    always @(negedge rst_n) m_q.delete();

    always @(posedge clk) begin
        bit rdy, aa, ba;
        if (rst_n) begin
            rdy = (m_q.size() <= DEPTH - 2);
            aa  = a_valid && rdy;
            ba  = b_valid && rdy;
            if (m_q.size() != 0) void'(m_q.pop_front());
            if (aa && a_addr != '0 && !(ba && b_addr == a_addr)) m_q.push_back('{a_addr, a_data});
            if (ba && b_addr != '0) m_q.push_back('{b_addr, b_data});
        end
    end

    // Compare process: outputs against the model, every cycle, away from the rising edge.
    always @(negedge clk) begin
        #2;
        check("m_rf_we", rf_we, m_q.size() != 0);
        if (m_q.size() != 0) begin
            check("m_rf_addr", rf_addr, m_q[0].addr);
            check("m_rf_wd", rf_wd, m_q[0].data);
        end
        check("m_q_count", q_count, m_q.size());
        check("m_q_empty", q_empty, m_q.size() == 0);
        check("m_a_ready", a_ready, m_q.size() <= DEPTH - 2);
        check("m_b_ready", b_ready, m_q.size() <= DEPTH - 2);
        check("m_busy1", chk_busy1, model_busy(chk_addr1));
        check("m_busy2", chk_busy2, model_busy(chk_addr2));
    end

    task automatic drive(input logic av, input logic [AW-1:0] aa, input logic [DW-1:0] ad,
                         input logic bv, input logic [AW-1:0] ba, input logic [DW-1:0] bd);
        a_valid = av; a_addr = aa; a_data = ad;
        b_valid = bv; b_addr = ba; b_data = bd;
    endtask

    task automatic idle();
        drive(1'b0, '0, '0, 1'b0, '0, '0);
    endtask

    // Stream bookkeeping: issue order and observed writes.
    wb_req_t s_exp[$];
    int      s_writes;

    task automatic observe_stream();
        wb_req_t e;
        if (rf_we) begin
            s_writes++;
            if (s_exp.size() == 0) check("stream_extra_write", 1, 0);
            else begin
                e = s_exp.pop_front();
                check("stream_addr", rf_addr, e.addr);
                check("stream_wd", rf_wd, e.data);
            end
        end
    endtask

    initial begin
        wb_req_t ra, rb;
        int      k, pairs, stale;
        bit      new_req, hit3;

        // Reset state, held before any edge is released.
        chk_addr1 = 5'd5; chk_addr2 = 5'd3;
        #12;
        check("rst_rf_we", rf_we, 1'b0);
        check("rst_rf_addr", rf_addr, 5'd0);
        check("rst_rf_wd", rf_wd, 32'd0);
        check("rst_q_count", q_count, 0);
        check("rst_q_empty", q_empty, 1'b1);
        check("rst_a_ready", a_ready, 1'b1);
        check("rst_b_ready", b_ready, 1'b1);
        check("rst_busy1", chk_busy1, 1'b0);
        #10 rst_n = 1'b1;

        // Single lane A write.
        @(negedge clk); drive(1'b1, 5'd5, 32'h11, 1'b0, '0, '0);
        @(negedge clk); idle(); #2;
        check("t1_we", rf_we, 1'b1);
        check("t1_addr", rf_addr, 5'd5);
        check("t1_wd", rf_wd, 32'h11);
        check("t1_busy", chk_busy1, 1'b1);
        @(negedge clk); #2;
        check("t1_we_off", rf_we, 1'b0);
        check("t1_empty", q_empty, 1'b1);

        // Pair with distinct registers, written in program order.
        @(negedge clk); chk_addr1 = 5'd7; drive(1'b1, 5'd3, 32'hAA, 1'b1, 5'd7, 32'hBB);
        @(negedge clk); idle(); #2;
        check("t2_addr0", rf_addr, 5'd3);
        check("t2_wd0", rf_wd, 32'hAA);
        check("t2_cnt", q_count, 2);
        check("t2_busy0", chk_busy1, 1'b1);
        @(negedge clk); #2;
        check("t2_addr1", rf_addr, 5'd7);
        check("t2_wd1", rf_wd, 32'hBB);
        check("t2_busy1", chk_busy1, 1'b1);
        @(negedge clk); #2;
        check("t2_we_off", rf_we, 1'b0);
        check("t2_busy_off", chk_busy1, 1'b0);

        // Same register on both lanes: younger wins.
        @(negedge clk); drive(1'b1, 5'd9, 32'h1, 1'b1, 5'd9, 32'h2);
        @(negedge clk); idle(); #2;
        check("t3_addr", rf_addr, 5'd9);
        check("t3_wd", rf_wd, 32'h2);
        check("t3_cnt", q_count, 1);
        @(negedge clk); #2;
        check("t3_we_off", rf_we, 1'b0);

        // Write to x0 is accepted but never reaches the register file.
        @(negedge clk); chk_addr1 = 5'd0; drive(1'b1, 5'd0, 32'hFF, 1'b0, '0, '0); #2;
        check("t4_ready", a_ready, 1'b1);
        @(negedge clk); idle(); #2;
        check("t4_we", rf_we, 1'b0);
        check("t4_cnt", q_count, 0);
        check("t4_busy0", chk_busy1, 1'b0);

        // Saturating stream of distinct pairs; requests hold while not ready.
        s_exp.delete(); s_writes = 0; k = 0; pairs = 0; new_req = 1'b1;
        for (int c = 0; c < 16; c++) begin
            @(negedge clk);
            if (new_req) begin
                ra = '{AW'((2 * k) % 30 + 1), $urandom};
                rb = '{AW'((2 * k + 1) % 30 + 1), $urandom};
                k++;
            end
            chk_addr1 = ra.addr; chk_addr2 = rb.addr;
            drive(1'b1, ra.addr, ra.data, 1'b1, rb.addr, rb.data);
            #2;
            observe_stream();
            new_req = a_ready;
            if (a_ready) begin
                s_exp.push_back(ra); s_exp.push_back(rb); pairs++;
            end
        end
        @(negedge clk); idle();
        for (int c = 0; c < 12; c++) begin
            #2; observe_stream();
            @(negedge clk);
        end
        check("stream_all_written", s_exp.size(), 0);
        check("stream_write_count", s_writes, 2 * pairs);
        check("stream_wrapped", pairs > DEPTH, 1'b1);

        // Build up to three pending entries, then pulse reset mid-cycle.
        hit3 = 1'b0;
        for (int c = 0; c < 10 && !hit3; c++) begin
            @(negedge clk);
            drive(1'b1, AW'(2 * c + 1), $urandom, 1'b1, AW'(2 * c + 2), $urandom);
            #2;
            if (q_count == CW'(3)) hit3 = 1'b1;
        end
        check("rst_reach_count3", hit3, 1'b1);
        #1 rst_n = 1'b0;
        #1;
        check("rst_async_we", rf_we, 1'b0);
        check("rst_async_cnt", q_count, 0);
        check("rst_async_empty", q_empty, 1'b1);
        idle();
        @(negedge clk); #3 rst_n = 1'b1;
        stale = 0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk); #2;
            if (rf_we) stale++;
        end
        check("rst_no_stale_write", stale, 0);

        // Random traffic with frequent x0 targets and register collisions.
        for (int c = 0; c < 400; c++) begin
            @(negedge clk);
            chk_addr1 = AW'($urandom_range(0, 7));
            chk_addr2 = AW'($urandom_range(0, 7));
            drive($urandom_range(0, 99) < 70, AW'($urandom_range(0, 7)), $urandom,
                  $urandom_range(0, 99) < 70, AW'($urandom_range(0, 7)), $urandom);
        end
        @(negedge clk); idle();
        repeat (8) @(negedge clk);
        #3;

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
